// File: rtl/regfile_dump.sv
// Register-file debug dump: walks FIRST_REG..LAST_REG through a dedicated read port and
// streams each register as an index byte plus four data bytes (MSB first) on a valid/ready byte link.
module regfile_dump #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_Start,
    output logic        o_Busy,
    output logic        o_Done,
    output logic [4:0]  o_Dump_register,
    input  logic [31:0] i_Dump_data,
    output logic [7:0]  o_Tx_data,
    output logic        o_Tx_valid,
    input  logic        i_Tx_ready
);

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND_IDX,
        SEND_DATA,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  reg_cnt;
    logic [31:0] word;
    logic [1:0]  byte_cnt;

    assign o_Dump_register = reg_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        o_Busy     = 1'b1;
        o_Done     = 1'b0;
        o_Tx_valid = 1'b0;
        o_Tx_data  = 8'h00;
        case (state)
            IDLE: begin
                o_Busy = 1'b0;
                if (i_Start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = SEND_IDX;
            end
            SEND_IDX: begin
                o_Tx_valid = 1'b1;
                o_Tx_data  = {3'b000, reg_cnt};
                if (i_Tx_ready) begin
                    state_nxt = SEND_DATA;
                end
            end
            SEND_DATA: begin
                o_Tx_valid = 1'b1;
                o_Tx_data  = word[31:24];
                if (i_Tx_ready && byte_cnt == 2'd3) begin
                    state_nxt = (reg_cnt == LAST_IDX) ? DONE : LOAD;
                end
            end
            DONE: begin
                o_Done    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Valid and data are decoded from state and only move on a handshake, so they stay
    // stable while the transmitter stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_cnt  <= FIRST_IDX;
            word     <= 32'h0;
            byte_cnt <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    reg_cnt <= FIRST_IDX;
                end
                LOAD: begin
                    word <= i_Dump_data;
                end
                SEND_IDX: begin
                    if (i_Tx_ready) begin
                        byte_cnt <= 2'd0;
                    end
                end
                SEND_DATA: begin
                    if (i_Tx_ready) begin
                        word     <= word << 8;
                        byte_cnt <= byte_cnt + 2'd1;
                        // LAST_REG ends the walk here, so the counter never wraps to 0.
                        if (byte_cnt == 2'd3 && reg_cnt != LAST_IDX) begin
                            reg_cnt <= reg_cnt + 5'd1;
                        end
                    end
                end
                DONE: begin
                    reg_cnt <= FIRST_IDX;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: a full-range and an 8..9 sub-range instance share one
// register-file model with write-through bypass; byte streams are compared against a snapshot model.
module tb_regfile_dump;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_Start = 1'b0;
    logic        i_Tx_ready = 1'b0;
    logic        sel = 1'b0;

    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = 5'd0;
    logic [31:0] wr_data = 32'h0;
    logic [31:0] regs [32] = '{default: 32'h0};
    logic [31:0] img [32] = '{default: 32'h0};

    logic        m_busy, m_done, m_valid, s_busy, s_done, s_valid;
    logic [4:0]  m_reg, s_reg;
    logic [31:0] m_rd, s_rd;
    logic [7:0]  m_data, s_data;
    logic        mon_busy, mon_done, mon_valid;
    logic [7:0]  mon_data;

    int checks = 0;
    int errors = 0;
    logic [7:0] got [$];
    int done_cycle;
    int stalls;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_en && wr_addr != 5'd0) regs[wr_addr] <= wr_data;
    end

    assign m_rd = (m_reg == 5'd0) ? 32'h0 : (wr_en && wr_addr == m_reg) ? wr_data : regs[m_reg];
    assign s_rd = (s_reg == 5'd0) ? 32'h0 : (wr_en && wr_addr == s_reg) ? wr_data : regs[s_reg];

    assign mon_busy  = sel ? s_busy  : m_busy;
    assign mon_done  = sel ? s_done  : m_done;
    assign mon_valid = sel ? s_valid : m_valid;
    assign mon_data  = sel ? s_data  : m_data;

    regfile_dump dut (
        .clk(clk), .reset(reset), .i_Start(i_Start && !sel),
        .o_Busy(m_busy), .o_Done(m_done), .o_Dump_register(m_reg), .i_Dump_data(m_rd),
        .o_Tx_data(m_data), .o_Tx_valid(m_valid), .i_Tx_ready(i_Tx_ready)
    );

    regfile_dump #(.FIRST_REG(8), .LAST_REG(9)) dut_sub (
        .clk(clk), .reset(reset), .i_Start(i_Start && sel),
        .o_Busy(s_busy), .o_Done(s_done), .o_Dump_register(s_reg), .i_Dump_data(s_rd),
        .o_Tx_data(s_data), .o_Tx_valid(s_valid), .i_Tx_ready(i_Tx_ready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_reg(input int a, input logic [31:0] d);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = 5'(a); wr_data = d;
        img[a] = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic clear_regs();
        for (int r = 1; r < 32; r++) set_reg(r, 32'h0);
    endtask

    // Runs one dump; the expected stream is each register's value as of its snapshot, index first.
    task automatic run_dump(input bit sub, input int ready_pct, input int mid_start, input bit bypass);
        logic [7:0]  exp_q [$];
        logic [31:0] v;
        int first, last, busy_bad, mism, first_bad;
        bit pend;
        logic [7:0] pend_data;
        first = sub ? 8 : 0;
        last  = sub ? 9 : 31;
        for (int r = first; r <= last; r++) begin
            v = (r == 0) ? 32'h0 : img[r];
            if (bypass && r == 5) v = 32'hCAFEF00D;
            exp_q.push_back(8'(r));
            for (int b = 3; b >= 0; b--) exp_q.push_back(v[8*b +: 8]);
        end
        got.delete();
        done_cycle = -1; stalls = 0; busy_bad = 0; pend = 1'b0; pend_data = 8'h00;
        @(negedge clk);
        sel = sub; i_Start = 1'b1;
        for (int n = 1; n <= 2000; n++) begin
            @(posedge clk); #1;
            i_Start    = (n == mid_start);
            i_Tx_ready = ($urandom_range(0, 99) < ready_pct);
            wr_en = 1'b0;
            if (bypass && n == 31) begin
                wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hCAFEF00D;
            end else if (bypass && n == 32) begin
                wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h11111111;
            end
            @(negedge clk);
            if (pend) check("held byte stable", {mon_valid, mon_data}, {1'b1, pend_data});
            pend = 1'b0;
            if (!mon_busy) busy_bad++;
            if (mon_valid && i_Tx_ready) begin
                got.push_back(mon_data);
            end else if (mon_valid) begin
                pend = 1'b1; pend_data = mon_data; stalls++;
            end
            if (mon_done) begin
                done_cycle = n;
                break;
            end
        end
        @(posedge clk); #1;
        i_Start = 1'b0; wr_en = 1'b0;
        if (bypass) img[5] = 32'h11111111;
        check("done seen in budget", done_cycle >= 0, 1);
        check("done cycle", done_cycle, 6 * (last - first + 1) + 1 + stalls);
        check("busy through dump", busy_bad, 0);
        check("byte count", got.size(), exp_q.size());
        mism = 0; first_bad = -1;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            if (got[i] !== exp_q[i]) begin
                mism++;
                if (first_bad < 0) first_bad = i;
            end
        end
        check($sformatf("stream mismatches (first at %0d)", first_bad), mism, 0);
        @(negedge clk);
        check("done is one pulse", mon_done, 0);
        check("idle after done", mon_busy, 0);
    endtask

    typedef struct {
        int          ra;
        logic [31:0] va;
        int          rb;
        logic [31:0] vb;
        int          ready_pct;
        int          mid_start;
        logic [39:0] grp_a;
        logic [39:0] grp_b;
    } vec_t;

    initial begin
        vec_t vecs [3];
        logic [39:0] grp;
        vecs[0] = '{1, 32'h12345678, 29, 32'h000007FC, 100, 0,  40'h0112345678, 40'h1D000007FC};
        vecs[1] = '{1, 32'h12345678, 29, 32'h000007FC, 30,  0,  40'h0112345678, 40'h1D000007FC};
        vecs[2] = '{1, 32'h12345678, 29, 32'h000007FC, 100, 77, 40'h0112345678, 40'h1D000007FC};

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", m_busy, 0);
        check("reset done", m_done, 0);
        check("reset valid/data", {m_valid, m_data}, 9'h000);
        check("reset dump register", m_reg, 5'd0);
        check("reset sub dump register", s_reg, 5'd8);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 3; i++) begin
            clear_regs();
            set_reg(vecs[i].ra, vecs[i].va);
            set_reg(vecs[i].rb, vecs[i].vb);
            run_dump(1'b0, vecs[i].ready_pct, vecs[i].mid_start, 1'b0);
            grp = 40'h0;
            if (got.size() == 160) begin
                for (int b = 0; b < 5; b++) grp = {grp[31:0], got[5 * vecs[i].ra + b]};
            end
            check($sformatf("vec%0d group a", i), grp, vecs[i].grp_a);
            grp = 40'h0;
            if (got.size() == 160) begin
                for (int b = 0; b < 5; b++) grp = {grp[31:0], got[5 * vecs[i].rb + b]};
            end
            check($sformatf("vec%0d group b", i), grp, vecs[i].grp_b);
        end

        // Sub-range 8..9 with a known first register.
        clear_regs();
        set_reg(8, 32'hDEADBEEF);
        run_dump(1'b1, 100, 0, 1'b0);
        check("sub-range head", got.size() >= 6 ? {got[0], got[1], got[2], got[3], got[4], got[5]} : 48'h0,
              48'h08DEADBEEF09);

        // Bypass capture in r5's LOAD cycle; the following write must not leak in.
        clear_regs();
        run_dump(1'b0, 100, 0, 1'b1);
        check("bypass r5 group", got.size() == 160 ? {got[25], got[26], got[27], got[28], got[29]} : 40'h0,
              40'h05CAFEF00D);

        // Start held high: sub instance restarts right after DONE.
        @(negedge clk);
        sel = 1'b1; i_Start = 1'b1; i_Tx_ready = 1'b1;
        for (int n = 1; n <= 28; n++) begin
            @(posedge clk); #1;
            if (n > 16) i_Start = 1'b0;
            @(negedge clk);
            if (n == 13) check("hold: first done", mon_done, 1);
            if (n == 14) check("hold: idle gap", mon_busy, 0);
            if (n == 16) check("hold: restart index byte", {mon_valid, mon_data}, {1'b1, 8'h08});
            if (n == 27) check("hold: second done", mon_done, 1);
            if (n == 28) check("hold: idle at end", mon_busy, 0);
        end
        i_Start = 1'b0;

        // Reset in the third data byte of r3 (cycle 23), then a clean restart from r0.
        @(negedge clk);
        sel = 1'b0; i_Start = 1'b1; i_Tx_ready = 1'b1;
        for (int n = 1; n <= 23; n++) begin
            @(posedge clk); #1;
            i_Start = 1'b0;
        end
        @(negedge clk);
        check("pre-reset r3 byte valid", mon_valid, 1);
        reset = 1'b1;
        #1;
        check("async reset valid", m_valid, 0);
        check("async reset busy", m_busy, 0);
        check("async reset dump register", m_reg, 5'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("no done after reset", m_done, 0);
        run_dump(1'b0, 100, 0, 1'b0);
        check("restart first byte", got.size() > 0 ? got[0] : 8'hFF, 8'h00);

        // Randomized contents with random backpressure on both instances.
        for (int r = 1; r < 32; r++) set_reg(r, $urandom());
        run_dump(1'b0, 50, 0, 1'b0);
        run_dump(1'b1, 30, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
